gen_iir_ctrl: RTL and testbench
===============================

Name: gen_iir_ctrl

Overview:
- Parametrised successor to the single-pole ADC→IIR→DAC sample controller.
- Sequences one ADC conversion and one DAC conversion in parallel per sample period.
- Selects one of NCH ADC channels and applies a run-time-selectable mode: shift-coefficient low-pass, bypass, or first-difference high-pass.
- Saturates the result to W bits, seeds filter history on reset and on channel change, and emits a per-sample strobe.
- Sits between the PmodAD1 and PmodDA2 serial interface modules, clocked by the slow generator clock.

Parameters:
- W, 12, sample width in bits for ADC and DAC data (unsigned, offset binary).
- NCH, 2, number of ADC channels on adcdata.
- CSW, 1, width of chsel; 2^CSW >= NCH.
- SA, 1, right-shift applied to x(n-1) in LPF.
- SB, 2, right-shift applied to x(n) in LPF.
- SC, 2, right-shift applied to y(n-1) in LPF.
- DACCMD, 0, constant 2-bit DAC command value.

Ports:
- genclk  in  1  sample-sequencer clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- chsel  in  CSW  ADC channel select; values >= NCH select channel 0.
- mode  in  2  00 = LPF, 01 = bypass, 10 = HPF, 11 = bypass.
- adcdav  out  1  ADC conversion request (high = convert).
- davadc  in  1  ADC conversion done; data valid on adcdata.
- adcdata  in  NCH*W  channel k occupies bits [k*W+W-1 : k*W].
- dacdav  out  1  DAC conversion request (high = convert dacdata).
- davdac  in  1  DAC conversion done.
- dacdata  out  W  sample to DAC.
- daccmd  out  2  DAC command, constant DACCMD.
- sample_stb  out  1  one-cycle pulse when dacdata is updated.

Behaviour:
- Reset values (asynchronous): adcdav=0, dacdav=0, dacdata=0, daccmd=DACCMD, sample_stb=0, state=IDLE, seed flag=1, history registers=0.
- IDLE: on the first genclk edge after reset deasserts → REQ; adcdav=dacdav=1.
- REQ: hold adcdav=dacdav=1 until davadc=1 AND davdac=1 are sampled on the same edge.
  - If only one done signal is high, keep waiting with both requests held.
  - On the edge where both are high: adcdav=dacdav=0, latch x = selected channel, latch chsel and mode, → CALC.
- CALC (exactly one cycle):
  - Compute y.
  - Update dacdata and history.
  - Pulse sample_stb=1.
  - Set adcdav=dacdav=1 and return to REQ.
  - Requests are therefore low for exactly one genclk cycle per sample. dacdata changes on the same edge that dacdav rises.
- DAC output lags: the value computed from ADC sample n is converted during the sample n+1 period.
- Seeding: if the seed flag is set, or latched chsel differs from the previous latched chsel, load xp=x and yp=x before computing, then clear the flag.
- LPF: s = (xp>>SA) + (x>>SB) + (yp>>SC), computed at W+2 bits; y = min(s, 2^W-1).
- HPF: d = x - xp, signed W+1 bits; s = 2^(W-1) + (d>>>1), arithmetic shift; y clamped to [0, 2^W-1].
- Bypass: y = x.
- History update, all modes, every CALC: xp←x; yp←LPF result (saturated). Switching to LPF therefore continues without a transient.
- A mode or chsel change takes effect only at latch time; mid-sample changes are ignored.
- Reset mid-sample: immediate return to reset values; any pending conversion done signals are ignored until REQ is re-entered.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then model ADC/DAC done after 10 cycles, ch0 constant 2000, mode LPF → first dacdata=2000 (seeded), every subsequent sample 2000; sample_stb once per sample; requests low exactly 1 cycle.
2. LPF step: seed with 0, then x=4000 → dacdata sequence 1000, 3250, 3812 (integer shifts).
3. Params SA=0, SB=1, SC=1, constant x=4095 → s=8189, dacdata saturates to 4095 every sample.
4. HPF: x=1000 (seed) → 2048; x=3000 → 3048; x=3000 → 2048; x=4095 after 0 → 4095; x=0 after 4095 → 0 (clamped).
5. Handshake: davadc high 5 cycles before davdac → requests stay high, no capture until both are high; then chsel 0→1 with ch1=500 → seeded, dacdata=500 in LPF.
6. Assert reset while in CALC → all outputs 0 asynchronously; after release, first sample is re-seeded; chsel=3 with NCH=2 → channel 0 used.

Source files
------------

// File: rtl/gen_iir_ctrl.sv
// Sample sequencer between a serial ADC and a serial DAC: one paired conversion
// per sample period, a selectable channel, and LPF / bypass / HPF with saturation.
module gen_iir_ctrl #(
  parameter int          W      = 12,
  parameter int          NCH    = 2,
  parameter int          CSW    = 1,
  parameter int          SA     = 1,
  parameter int          SB     = 2,
  parameter int          SC     = 2,
  parameter logic [1:0]  DACCMD = 2'd0
) (
  input  logic             genclk,
  input  logic             reset,
  input  logic [CSW-1:0]   chsel,
  input  logic [1:0]       mode,
  output logic             adcdav,
  input  logic             davadc,
  input  logic [NCH*W-1:0] adcdata,
  output logic             dacdav,
  input  logic             davdac,
  output logic [W-1:0]     dacdata,
  output logic [1:0]       daccmd,
  output logic             sample_stb
);

  localparam int SW = W + 2;
  localparam logic [SW-1:0] MID = {{(SW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, CALC} state_t;

  state_t         state;
  logic [W-1:0]   x_lat;
  logic [CSW-1:0] ch_lat;
  logic [CSW-1:0] ch_prev;
  logic [1:0]     mode_lat;
  logic [W-1:0]   xp;
  logic [W-1:0]   yp;
  logic           seed;

  logic [W-1:0]         sel_x;
  logic                 reseed;
  logic [W-1:0]         xp_eff;
  logic [W-1:0]         yp_eff;
  logic [SW-1:0]        lpf_sum;
  logic [W-1:0]         lpf_y;
  logic signed [W:0]    diff;
  logic signed [W:0]    half;
  logic signed [SW-1:0] hsum;
  logic [W-1:0]         hpf_y;
  logic [W-1:0]         y;

  assign daccmd = DACCMD;

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_x = adcdata[W-1:0];
    for (int k = 0; k < NCH; k++) begin
      if (chsel == CSW'(k)) sel_x = adcdata[k*W +: W];
    end
  end

  // History is seeded from the new sample after reset or a channel change.
  always_comb begin
    reseed  = seed | (ch_lat != ch_prev);
    xp_eff  = reseed ? x_lat : xp;
    yp_eff  = reseed ? x_lat : yp;

    lpf_sum = SW'(xp_eff >> SA) + SW'(x_lat >> SB) + SW'(yp_eff >> SC);
    lpf_y   = (lpf_sum[SW-1:W] != '0) ? '1 : lpf_sum[W-1:0];

    diff    = $signed({1'b0, x_lat}) - $signed({1'b0, xp_eff});
    half    = diff >>> 1;
    hsum    = $signed(MID) + $signed({half[W], half});
    if (hsum[SW-1])  hpf_y = '0;
    else if (hsum[W]) hpf_y = '1;
    else             hpf_y = hsum[W-1:0];

    case (mode_lat)
      2'b00:   y = lpf_y;
      2'b10:   y = hpf_y;
      default: y = x_lat;
    endcase
  end

  always_ff @(posedge genclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      adcdav     <= 1'b0;
      dacdav     <= 1'b0;
      dacdata    <= '0;
      sample_stb <= 1'b0;
      seed       <= 1'b1;
      xp         <= '0;
      yp         <= '0;
      x_lat      <= '0;
      ch_lat     <= '0;
      ch_prev    <= '0;
      mode_lat   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, matching hardware.
      sample_stb <= 1'b0;
      case (state)
        IDLE: begin
          adcdav <= 1'b1;
          dacdav <= 1'b1;
          state  <= REQ;
        end
        REQ: begin
          if (davadc && davdac) begin
            adcdav   <= 1'b0;
            dacdav   <= 1'b0;
            x_lat    <= sel_x;
            ch_lat   <= chsel;
            mode_lat <= mode;
            state    <= CALC;
          end
        end
        CALC: begin
          // yp always tracks the LPF so a later switch into LPF has no transient.
          dacdata    <= y;
          xp         <= x_lat;
          yp         <= lpf_y;
          ch_prev    <= ch_lat;
          seed       <= 1'b0;
          sample_stb <= 1'b1;
          adcdav     <= 1'b1;
          dacdav     <= 1'b1;
          state      <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_iir_ctrl.sv
// Bench for gen_iir_ctrl: two instances (default shifts, and SA=0/SB=1/SC=1)
// driven by a shared ADC/DAC responder and compared against an arithmetic model.
module tb_gen_iir_ctrl;

  localparam int W    = 12;
  localparam int MAXV = 4095;

  logic          genclk = 1'b0;
  logic          reset;
  logic [1:0]    chsel;
  logic [1:0]    mode;
  logic          davadc;
  logic          davdac;
  logic [2*W-1:0] adcdata;

  logic          adcdav,  dacdav,  sample_stb;
  logic [W-1:0]  dacdata;
  logic [1:0]    daccmd;
  logic          adcdav_s, dacdav_s, sample_stb_s;
  logic [W-1:0]  dacdata_s;
  logic [1:0]    daccmd_s;

  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 = default DUT, 1 = steep-shift DUT.
  bit m_seed;
  int m_prev_ch;
  int m_xp [2];
  int m_yp [2];
  int m_sa [2] = '{1, 0};
  int m_sb [2] = '{2, 1};
  int m_sc [2] = '{2, 1};

  always #5 genclk = ~genclk;

  gen_iir_ctrl #(.W(W), .NCH(2), .CSW(2), .SA(1), .SB(2), .SC(2), .DACCMD(2'd0)) dut (
    .genclk(genclk), .reset(reset), .chsel(chsel), .mode(mode),
    .adcdav(adcdav), .davadc(davadc), .adcdata(adcdata),
    .dacdav(dacdav), .davdac(davdac), .dacdata(dacdata),
    .daccmd(daccmd), .sample_stb(sample_stb)
  );

  gen_iir_ctrl #(.W(W), .NCH(2), .CSW(2), .SA(0), .SB(1), .SC(1), .DACCMD(2'd0)) dut_sat (
    .genclk(genclk), .reset(reset), .chsel(chsel), .mode(mode),
    .adcdav(adcdav_s), .davadc(davadc), .adcdata(adcdata),
    .dacdav(dacdav_s), .davdac(davdac), .dacdata(dacdata_s),
    .daccmd(daccmd_s), .sample_stb(sample_stb_s)
  );

  function automatic int lpf_ref(int xp, int x, int yp, int i);
    int s;
    s = xp / (1 << m_sa[i]) + x / (1 << m_sb[i]) + yp / (1 << m_sc[i]);
    return (s > MAXV) ? MAXV : s;
  endfunction

  function automatic int hpf_ref(int x, int xp);
    int d, h, s;
    d = x - xp;
    h = (d >= 0) ? d / 2 : -((-d + 1) / 2);   // floor(d/2)
    s = 2048 + h;
    if (s < 0) s = 0;
    if (s > MAXV) s = MAXV;
    return s;
  endfunction

  task automatic model_reset();
    m_seed    = 1'b1;
    m_prev_ch = 0;
    for (int i = 0; i < 2; i++) begin
      m_xp[i] = 0;
      m_yp[i] = 0;
    end
  endtask

  task automatic model_step(input int x, input int cs, input int md, output int ey0, output int ey1);
    bit reseed;
    int xp, yp, lp, ey [2];
    reseed = m_seed || (cs != m_prev_ch);
    for (int i = 0; i < 2; i++) begin
      xp = reseed ? x : m_xp[i];
      yp = reseed ? x : m_yp[i];
      lp = lpf_ref(xp, x, yp, i);
      if (md == 0)      ey[i] = lp;
      else if (md == 2) ey[i] = hpf_ref(x, xp);
      else              ey[i] = x;
      m_xp[i] = x;
      m_yp[i] = lp;
    end
    m_seed    = 1'b0;
    m_prev_ch = cs;
    ey0 = ey[0];
    ey1 = ey[1];
  endtask

  // One full sample period. abort=1 asserts reset while the DUT is in CALC.
  task automatic do_sample(input int c0, input int c1, input int cs, input int md,
                           input int lag_a, input int lag_d, input bit abort);
    int waited, x, ey0, ey1, n;
    adcdata = {W'(c1), W'(c0)};
    chsel   = 2'(cs);
    mode    = 2'(md);
    waited  = 0;
    while (!(adcdav && dacdav) && waited < 50) begin
      @(negedge genclk);
      waited++;
    end
    total++;
    if (!(adcdav && dacdav)) begin
      bad++;
      $display("FAIL req_timeout: adcdav=%0b dacdav=%0b required 1/1", adcdav, dacdav);
      return;
    end
    n = 0;
    forever begin
      davadc = (n >= lag_a);
      davdac = (n >= lag_d);
      if (davadc && davdac) break;
      @(negedge genclk);
      total++;
      if ({adcdav, dacdav, adcdav_s, dacdav_s} !== 4'b1111) begin
        bad++;
        $display("FAIL req_held: reqs=%b required 1111 (n=%0d)", {adcdav, dacdav, adcdav_s, dacdav_s}, n);
      end
      n++;
    end
    @(negedge genclk);
    total++;
    if ({adcdav, dacdav, sample_stb} !== 3'b000) begin
      bad++;
      $display("FAIL req_drop: adcdav=%0b dacdav=%0b stb=%0b required 0/0/0", adcdav, dacdav, sample_stb);
    end
    davadc  = 1'b0;
    davdac  = 1'b0;
    // Inputs scrambled after latch time must not affect this sample.
    mode    = ~2'(md);
    chsel   = 2'(cs + 1);
    adcdata = ~adcdata;
    if (abort) begin
      reset = 1'b1;
      #1;
      total++;
      if ({adcdav, dacdav, sample_stb, dacdata, dacdata_s} !== '0) begin
        bad++;
        $display("FAIL reset_in_calc: adcdav=%0b dacdav=%0b stb=%0b dacdata=%0d dacdata_s=%0d required all 0",
                 adcdav, dacdav, sample_stb, dacdata, dacdata_s);
      end
      model_reset();
      repeat (2) @(negedge genclk);
      reset = 1'b0;
      return;
    end
    x = (cs == 1) ? c1 : c0;
    model_step(x, cs, md, ey0, ey1);
    @(negedge genclk);
    total++;
    if (sample_stb !== 1'b1 || sample_stb_s !== 1'b1 || adcdav !== 1'b1 || dacdav !== 1'b1) begin
      bad++;
      $display("FAIL calc_strobe: stb=%0b stb_s=%0b adcdav=%0b dacdav=%0b required 1/1/1/1",
               sample_stb, sample_stb_s, adcdav, dacdav);
    end
    total++;
    if (dacdata !== W'(ey0)) begin
      bad++;
      $display("FAIL dacdata: got %0d required %0d (x=%0d cs=%0d mode=%0d)", dacdata, ey0, x, cs, md);
    end
    total++;
    if (dacdata_s !== W'(ey1)) begin
      bad++;
      $display("FAIL dacdata_sat: got %0d required %0d (x=%0d cs=%0d mode=%0d)", dacdata_s, ey1, x, cs, md);
    end
    @(negedge genclk);
    total++;
    if (sample_stb !== 1'b0) begin
      bad++;
      $display("FAIL stb_width: stb=%0b required 0", sample_stb);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    davadc  = 1'b0;
    davdac  = 1'b0;
    chsel   = '0;
    mode    = '0;
    adcdata = '0;
    repeat (3) @(negedge genclk);
    total++;
    if ({adcdav, dacdav, sample_stb, dacdata, daccmd} !== '0) begin
      bad++;
      $display("FAIL reset_values: adcdav=%0b dacdav=%0b stb=%0b dacdata=%0d daccmd=%0d required all 0",
               adcdav, dacdav, sample_stb, dacdata, daccmd);
    end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_const_lpf();
    test_reset();
    for (int i = 0; i < 4; i++) do_sample(2000, 123, 0, 0, 10, 10, 1'b0);
  endtask

  task automatic test_lpf_step();
    test_reset();
    do_sample(0, 0, 0, 0, 1, 1, 1'b0);
    for (int i = 0; i < 3; i++) do_sample(4000, 0, 0, 0, 1, 1, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) do_sample(4095, 0, 0, 0, 2, 0, 1'b0);
  endtask

  task automatic test_hpf();
    test_reset();
    do_sample(1000, 0, 0, 2, 1, 1, 1'b0);
    do_sample(3000, 0, 0, 2, 1, 1, 1'b0);
    do_sample(3000, 0, 0, 2, 1, 1, 1'b0);
    do_sample(0,    0, 0, 2, 1, 1, 1'b0);
    do_sample(4095, 0, 0, 2, 1, 1, 1'b0);
    do_sample(0,    0, 0, 2, 1, 1, 1'b0);
  endtask

  task automatic test_handshake();
    do_sample(1500, 500, 0, 0, 0, 5, 1'b0);
    do_sample(1500, 500, 1, 0, 0, 5, 1'b0);
    do_sample(1500, 500, 1, 0, 5, 0, 1'b0);
  endtask

  task automatic test_reset_in_calc();
    do_sample(3000, 900, 1, 1, 1, 1, 1'b0);
    do_sample(3000, 900, 1, 1, 1, 1, 1'b1);
    do_sample(700, 1500, 3, 0, 1, 1, 1'b0);
    do_sample(700, 1500, 3, 0, 1, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_sample(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_const_lpf();
    test_lpf_step();
    test_saturation();
    test_hpf();
    test_handshake();
    test_reset_in_calc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
